ddr_responder: RTL and testbench

DDR_RESPONDER -- requirements
Module: ddr_responder

---
 rtl/ddr_pkg.sv | 20 ++
 rtl/ddr_ram.sv | 42 ++++
 rtl/ddr_responder.sv | 157 +++++++++++++++
 tb/tb_ddr_responder.sv | 228 ++++++++++++++++++++++
 4 files changed

// File: rtl/ddr_pkg.sv
// rtl/ddr_pkg.sv - shared widths, FSM state type and burst helper for ddr_responder
package ddr_pkg;

  localparam int DDR_DATA_WIDTH  = 64;
  localparam int DDR_MASK_WIDTH  = 8;
  localparam int DDR_BURST_WIDTH = 8;
  localparam int DDR_CNT_WIDTH   = DDR_BURST_WIDTH + 1;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    WRITE = 2'd1,
    READ  = 2'd2
  } ddr_state_e;

  // A zero-length burst still moves one word.
  function automatic logic [DDR_BURST_WIDTH-1:0] eff_burst(input logic [DDR_BURST_WIDTH-1:0] len);
    return (len == '0) ? DDR_BURST_WIDTH'(1) : len;
  endfunction

endpackage

// File: rtl/ddr_ram.sv
// rtl/ddr_ram.sv - single-port byte-enabled 64-bit RAM with one-cycle registered read
module ddr_ram
  import ddr_pkg::*;
#(
  parameter int ADDR_WIDTH = 10
) (
  input  logic                      clock,
  input  logic                      reset,
  input  logic                      i_we,
  input  logic                      i_re,
  input  logic [ADDR_WIDTH-1:0]     i_addr,
  input  logic [DDR_MASK_WIDTH-1:0] i_be,
  input  logic [DDR_DATA_WIDTH-1:0] i_wdata,
  output logic [DDR_DATA_WIDTH-1:0] o_rdata
);

  localparam int DEPTH = 1 << ADDR_WIDTH;

  logic [DDR_DATA_WIDTH-1:0] r_mem [0:DEPTH-1];
  logic [DDR_DATA_WIDTH-1:0] r_rdata;

  // Storage is intentionally outside reset so contents survive it.
  always_ff @(posedge clock) begin
    if (i_we) begin
      for (int i = 0; i < DDR_MASK_WIDTH; i++) begin
        if (i_be[i]) r_mem[i_addr][8*i +: 8] <= i_wdata[8*i +: 8];
      end
    end
  end

  // Read register only moves on a read, so it doubles as a hold register.
  always_ff @(posedge clock) begin
    if (reset) begin
      r_rdata <= '0;
    end else if (i_re) begin
      r_rdata <= r_mem[i_addr];
    end
  end

  assign o_rdata = r_rdata;

endmodule

// File: rtl/ddr_responder.sv
// rtl/ddr_responder.sv - DDR-style burst memory responder with fixed read latency and stall injection
module ddr_responder
  import ddr_pkg::*;
#(
  parameter int ADDR_WIDTH    = 10,
  parameter int READ_LATENCY  = 2,
  parameter int BUSY_INTERVAL = 0
) (
  input  logic                       clock,
  input  logic                       reset,
  input  logic                       ddr_rd,
  input  logic                       ddr_wr,
  input  logic [31:0]                ddr_addr,
  input  logic [DDR_BURST_WIDTH-1:0] ddr_burstLength,
  input  logic [DDR_MASK_WIDTH-1:0]  ddr_mask,
  input  logic [DDR_DATA_WIDTH-1:0]  ddr_din,
  output logic [DDR_DATA_WIDTH-1:0]  ddr_dout,
  output logic                       ddr_waitReq,
  output logic                       ddr_valid
);

  localparam int                     CW        = DDR_CNT_WIDTH;
  localparam logic [ADDR_WIDTH-1:0]  IDX_ONE   = ADDR_WIDTH'(1);
  localparam logic [CW-1:0]          CNT_ONE   = CW'(1);
  localparam logic [CW-1:0]          CNT_TWO   = CW'(2);
  localparam logic [CW-1:0]          LAT       = CW'(READ_LATENCY);
  localparam bit                     BUSY_EN   = (BUSY_INTERVAL > 0);
  localparam logic [15:0]            BUSY_LAST = BUSY_EN ? 16'(BUSY_INTERVAL - 1) : 16'd0;

  ddr_state_e                 r_state, w_state_nxt;
  logic [ADDR_WIDTH-1:0]      r_idx, w_idx_nxt;
  logic [CW-1:0]              r_cnt, w_cnt_nxt;
  logic [15:0]                r_busy_cnt;
  logic                       w_busy;
  logic                       w_ram_we, w_ram_re;
  logic [ADDR_WIDTH-1:0]      w_ram_addr, w_cmd_idx;
  logic [DDR_BURST_WIDTH-1:0] w_burst;
  logic [READ_LATENCY-1:0]    r_vld;
  logic [DDR_DATA_WIDTH-1:0]  w_stage [0:READ_LATENCY-1];
  logic                       w_unused;

  assign w_cmd_idx = ddr_addr[ADDR_WIDTH+2:3];
  assign w_burst   = eff_burst(ddr_burstLength);
  assign w_unused  = ^{ddr_addr[31:ADDR_WIDTH+3], ddr_addr[2:0]};

  always_ff @(posedge clock) begin
    if (reset) begin
      r_busy_cnt <= '0;
    end else if (BUSY_EN) begin
      r_busy_cnt <= (r_busy_cnt == BUSY_LAST) ? 16'd0 : r_busy_cnt + 16'd1;
    end
  end

  assign w_busy      = BUSY_EN && (r_busy_cnt == BUSY_LAST);
  assign ddr_waitReq = reset | (r_state == READ) | w_busy;

  // In READ, r_cnt counts down the cycles left in READ; beats are still
  // being issued to the RAM while r_cnt >= READ_LATENCY.
  always_comb begin
    w_state_nxt = r_state;
    w_idx_nxt   = r_idx;
    w_cnt_nxt   = r_cnt;
    w_ram_we    = 1'b0;
    w_ram_re    = 1'b0;
    w_ram_addr  = r_idx;
    case (r_state)
      IDLE: begin
        if (ddr_rd && !ddr_waitReq) begin
          w_ram_re    = 1'b1;
          w_ram_addr  = w_cmd_idx;
          w_idx_nxt   = w_cmd_idx + IDX_ONE;
          w_cnt_nxt   = {1'b0, w_burst} + LAT - CNT_TWO;
          w_state_nxt = READ;
        end else if (ddr_wr && !ddr_waitReq) begin
          w_ram_we   = 1'b1;
          w_ram_addr = w_cmd_idx;
          w_idx_nxt  = w_cmd_idx + IDX_ONE;
          w_cnt_nxt  = {1'b0, w_burst} - CNT_ONE;
          if (w_burst != DDR_BURST_WIDTH'(1)) w_state_nxt = WRITE;
        end
      end
      WRITE: begin
        if (ddr_wr && !ddr_waitReq) begin
          w_ram_we  = 1'b1;
          w_idx_nxt = r_idx + IDX_ONE;
          w_cnt_nxt = r_cnt - CNT_ONE;
          if (r_cnt == CNT_ONE) w_state_nxt = IDLE;
        end
      end
      READ: begin
        if (r_cnt >= LAT) begin
          w_ram_re  = 1'b1;
          w_idx_nxt = r_idx + IDX_ONE;
        end
        if (r_cnt == '0) begin
          w_state_nxt = IDLE;
        end else begin
          w_cnt_nxt = r_cnt - CNT_ONE;
        end
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      r_state <= IDLE;
      r_idx   <= '0;
      r_cnt   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_idx   <= w_idx_nxt;
      r_cnt   <= w_cnt_nxt;
    end
  end

  ddr_ram #(
    .ADDR_WIDTH(ADDR_WIDTH)
  ) u_ram (
    .clock  (clock),
    .reset  (reset),
    .i_we   (w_ram_we),
    .i_re   (w_ram_re),
    .i_addr (w_ram_addr),
    .i_be   (ddr_mask),
    .i_wdata(ddr_din),
    .o_rdata(w_stage[0])
  );

  generate
    if (READ_LATENCY > 1) begin : g_vld_shift
      always_ff @(posedge clock) begin
        if (reset) r_vld <= '0;
        else       r_vld <= {r_vld[READ_LATENCY-2:0], w_ram_re};
      end
    end else begin : g_vld_single
      always_ff @(posedge clock) begin
        if (reset) r_vld <= '0;
        else       r_vld <= w_ram_re;
      end
    end

    // Each stage loads only when a beat arrives, so the last stage holds between beats.
    for (genvar g = 1; g < READ_LATENCY; g++) begin : g_pipe
      logic [DDR_DATA_WIDTH-1:0] r_dat;
      always_ff @(posedge clock) begin
        if (reset)           r_dat <= '0;
        else if (r_vld[g-1]) r_dat <= w_stage[g-1];
      end
      assign w_stage[g] = r_dat;
    end
  endgenerate

  assign ddr_valid = r_vld[READ_LATENCY-1];
  assign ddr_dout  = w_stage[READ_LATENCY-1];

endmodule

// File: tb/tb_ddr_responder.sv
// tb/tb_ddr_responder.sv - directed self-checking bench for ddr_responder
module tb_ddr_responder;

  logic        clk;
  logic        a_reset, a_rd, a_wr, a_waitReq, a_valid;
  logic [31:0] a_addr;
  logic [7:0]  a_len, a_mask;
  logic [63:0] a_din, a_dout;
  logic        b_reset, b_rd, b_wr, b_waitReq, b_valid;
  logic [31:0] b_addr;
  logic [7:0]  b_len, b_mask;
  logic [63:0] b_din, b_dout;

  int          n_cmp, n_fail;
  logic [63:0] wdata [0:15];
  logic [63:0] cap_data [0:15];
  int          cap_n, cap_first, cap_last, cap_wlow;

  ddr_responder #(.ADDR_WIDTH(10), .READ_LATENCY(2), .BUSY_INTERVAL(0)) u_dut (
    .clock(clk), .reset(a_reset), .ddr_rd(a_rd), .ddr_wr(a_wr), .ddr_addr(a_addr),
    .ddr_burstLength(a_len), .ddr_mask(a_mask), .ddr_din(a_din), .ddr_dout(a_dout),
    .ddr_waitReq(a_waitReq), .ddr_valid(a_valid)
  );

  ddr_responder #(.ADDR_WIDTH(10), .READ_LATENCY(1), .BUSY_INTERVAL(4)) u_dut_busy (
    .clock(clk), .reset(b_reset), .ddr_rd(b_rd), .ddr_wr(b_wr), .ddr_addr(b_addr),
    .ddr_burstLength(b_len), .ddr_mask(b_mask), .ddr_din(b_din), .ddr_dout(b_dout),
    .ddr_waitReq(b_waitReq), .ddr_valid(b_valid)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  // Beats after the first carry junk address/length to show they are ignored.
  task automatic do_write(input logic [31:0] addr, input int len, input logic [7:0] mask, input int gap);
    for (int k = 0; k < len; k++) begin
      if (k == gap) begin
        a_wr = 1'b0;
        step();
      end
      a_wr   = 1'b1;
      a_addr = (k == 0) ? addr : 32'hFFFF_FFF8;
      a_len  = (k == 0) ? 8'(len) : 8'd1;
      a_mask = mask;
      a_din  = wdata[k];
      step();
    end
    a_wr = 1'b0;
    step();
  endtask

  task automatic cap_read(input logic [31:0] addr, input logic [7:0] len);
    cap_n = 0; cap_first = -1; cap_last = -1; cap_wlow = -1;
    for (int k = 0; k < 16; k++) cap_data[k] = '0;
    a_rd = 1'b1; a_addr = addr; a_len = len;
    step();
    a_rd = 1'b0;
    for (int c = 1; c <= int'(len) + 12; c++) begin
      if (a_valid) begin
        if (cap_first < 0) cap_first = c;
        cap_last = c;
        if (cap_n < 16) cap_data[cap_n] = a_dout;
        cap_n++;
      end
      if (!a_waitReq && cap_wlow < 0) cap_wlow = c;
      step();
    end
  endtask

  task automatic test_reset();
    a_reset = 1'b1; b_reset = 1'b1;
    step(); step();
    n_cmp++; if (a_waitReq !== 1'b1) begin n_fail++; $display("FAIL reset_wait got=%b exp=1", a_waitReq); end
    n_cmp++; if (a_valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid got=%b exp=0", a_valid); end
    n_cmp++; if (a_dout !== 64'h0) begin n_fail++; $display("FAIL reset_dout got=%h exp=0", a_dout); end
    a_reset = 1'b0; b_reset = 1'b0;
    step();
    n_cmp++; if (a_waitReq !== 1'b0) begin n_fail++; $display("FAIL release_wait got=%b exp=0", a_waitReq); end
  endtask

  task automatic test_single();
    wdata[0] = 64'h1122334455667788;
    do_write(32'h10, 1, 8'hFF, -1);
    n_cmp++; if (a_waitReq !== 1'b0) begin n_fail++; $display("FAIL single_wr_idle got=%b exp=0", a_waitReq); end
    cap_read(32'h10, 8'd1);
    n_cmp++; if (cap_first !== 2) begin n_fail++; $display("FAIL single_first got=%0d exp=2", cap_first); end
    n_cmp++; if (cap_n !== 1) begin n_fail++; $display("FAIL single_count got=%0d exp=1", cap_n); end
    n_cmp++; if (cap_data[0] !== 64'h1122334455667788) begin n_fail++; $display("FAIL single_data got=%h exp=1122334455667788", cap_data[0]); end
    n_cmp++; if (cap_wlow !== 3) begin n_fail++; $display("FAIL single_wait_low got=%0d exp=3", cap_wlow); end
    n_cmp++; if (a_valid !== 1'b0 || a_dout !== 64'h1122334455667788) begin
      n_fail++; $display("FAIL single_hold got=%b/%h exp=0/1122334455667788", a_valid, a_dout);
    end
  endtask

  task automatic test_burst_gap();
    for (int k = 0; k < 4; k++) wdata[k] = 64'(k + 1);
    do_write(32'h40, 4, 8'hFF, 2);
    cap_read(32'h40, 8'd4);
    n_cmp++; if (cap_first !== 2 || cap_last !== 5) begin n_fail++; $display("FAIL burst_window got=%0d..%0d exp=2..5", cap_first, cap_last); end
    n_cmp++; if (cap_n !== 4) begin n_fail++; $display("FAIL burst_count got=%0d exp=4", cap_n); end
    for (int k = 0; k < 4; k++) begin
      n_cmp++; if (cap_data[k] !== 64'(k + 1)) begin n_fail++; $display("FAIL burst_beat%0d got=%h exp=%h", k, cap_data[k], 64'(k + 1)); end
    end
    n_cmp++; if (cap_wlow !== 6) begin n_fail++; $display("FAIL burst_wait_low got=%0d exp=6", cap_wlow); end
  endtask

  task automatic test_mask();
    wdata[0] = 64'hFFFF_FFFF_FFFF_FFFF;
    do_write(32'h0, 1, 8'hFF, -1);
    wdata[0] = 64'h0;
    do_write(32'h0, 1, 8'h0F, -1);
    cap_read(32'h0, 8'd1);
    n_cmp++; if (cap_data[0] !== 64'hFFFF_FFFF_0000_0000) begin n_fail++; $display("FAIL mask_data got=%h exp=ffffffff00000000", cap_data[0]); end
  endtask

  task automatic test_wrap();
    wdata[0] = 64'hAAAA_0000_0000_000A;
    wdata[1] = 64'hBBBB_0000_0000_000B;
    wdata[2] = 64'hCCCC_0000_0000_000C;
    do_write(32'h1FF8, 3, 8'hFF, -1);
    cap_read(32'h1FF8, 8'd3);
    n_cmp++; if (cap_n !== 3) begin n_fail++; $display("FAIL wrap_count got=%0d exp=3", cap_n); end
    n_cmp++; if (cap_data[0] !== 64'hAAAA_0000_0000_000A) begin n_fail++; $display("FAIL wrap_b0 got=%h exp=aaaa00000000000a", cap_data[0]); end
    n_cmp++; if (cap_data[1] !== 64'hBBBB_0000_0000_000B) begin n_fail++; $display("FAIL wrap_b1 got=%h exp=bbbb00000000000b", cap_data[1]); end
    n_cmp++; if (cap_data[2] !== 64'hCCCC_0000_0000_000C) begin n_fail++; $display("FAIL wrap_b2 got=%h exp=cccc00000000000c", cap_data[2]); end
    cap_read(32'h0, 8'd0);
    n_cmp++; if (cap_n !== 1) begin n_fail++; $display("FAIL len0_count got=%0d exp=1", cap_n); end
    n_cmp++; if (cap_data[0] !== 64'hBBBB_0000_0000_000B) begin n_fail++; $display("FAIL word0_data got=%h exp=bbbb00000000000b", cap_data[0]); end
    cap_read(32'h8000_3FFD, 8'd1);
    n_cmp++; if (cap_data[0] !== 64'hAAAA_0000_0000_000A) begin n_fail++; $display("FAIL addr_ignore got=%h exp=aaaa00000000000a", cap_data[0]); end
  endtask

  task automatic test_reset_mid();
    int nv;
    for (int k = 0; k < 8; k++) wdata[k] = 64'h100 + 64'(k);
    do_write(32'h80, 8, 8'hFF, -1);
    a_rd = 1'b1; a_addr = 32'h80; a_len = 8'd8;
    step();
    a_rd = 1'b0;
    step();
    n_cmp++; if (a_valid !== 1'b1 || a_dout !== 64'h100) begin n_fail++; $display("FAIL rmid_beat0 got=%b/%h exp=1/100", a_valid, a_dout); end
    step();
    n_cmp++; if (a_valid !== 1'b1 || a_dout !== 64'h101) begin n_fail++; $display("FAIL rmid_beat1 got=%b/%h exp=1/101", a_valid, a_dout); end
    a_reset = 1'b1;
    for (int c = 0; c < 2; c++) begin
      step();
      n_cmp++; if (a_valid !== 1'b0) begin n_fail++; $display("FAIL rmid_valid%0d got=%b exp=0", c, a_valid); end
      n_cmp++; if (a_waitReq !== 1'b1) begin n_fail++; $display("FAIL rmid_wait%0d got=%b exp=1", c, a_waitReq); end
    end
    a_reset = 1'b0;
    step();
    n_cmp++; if (a_waitReq !== 1'b0) begin n_fail++; $display("FAIL rmid_release got=%b exp=0", a_waitReq); end
    nv = 0;
    for (int c = 0; c < 12; c++) begin
      if (a_valid) nv++;
      step();
    end
    n_cmp++; if (nv !== 0) begin n_fail++; $display("FAIL rmid_no_beats got=%0d exp=0", nv); end
    cap_read(32'h90, 8'd1);
    n_cmp++; if (cap_data[0] !== 64'h102) begin n_fail++; $display("FAIL rmid_mem_kept got=%h exp=102", cap_data[0]); end
  endtask

  task automatic test_busy();
    int nh, fh, lh, n;
    nh = 0; fh = -1; lh = -1;
    for (int c = 0; c < 12; c++) begin
      if (b_waitReq) begin
        if (fh < 0) fh = c;
        lh = c;
        nh++;
      end
      step();
    end
    n_cmp++; if (nh !== 3) begin n_fail++; $display("FAIL busy_pulses got=%0d exp=3", nh); end
    n_cmp++; if (lh - fh !== 8) begin n_fail++; $display("FAIL busy_period got=%0d exp=8", lh - fh); end
    b_wr = 1'b1; b_rd = 1'b0; b_addr = 32'h28; b_len = 8'd1; b_mask = 8'hFF; b_din = 64'hA5A5_A5A5_A5A5_A5A5;
    n = 0;
    while (b_waitReq && n < 20) begin step(); n++; end
    n_cmp++; if (n >= 20) begin n_fail++; $display("FAIL busy_wr_accept got=stalled exp=accepted"); end
    step();
    b_wr = 1'b0;
    step();
    b_rd = 1'b1; b_wr = 1'b1; b_din = 64'hDEAD_BEEF_DEAD_BEEF;
    n = 0;
    while (b_waitReq && n < 20) begin step(); n++; end
    n_cmp++; if (n >= 20) begin n_fail++; $display("FAIL busy_rw_accept got=stalled exp=accepted"); end
    step();
    b_rd = 1'b0; b_wr = 1'b0;
    n_cmp++; if (b_valid !== 1'b1 || b_dout !== 64'hA5A5_A5A5_A5A5_A5A5) begin n_fail++; $display("FAIL rw_read got=%b/%h exp=1/a5a5a5a5a5a5a5a5", b_valid, b_dout); end
    n_cmp++; if (b_waitReq !== 1'b1) begin n_fail++; $display("FAIL rw_wait got=%b exp=1", b_waitReq); end
    step();
    n_cmp++; if (b_valid !== 1'b0) begin n_fail++; $display("FAIL rw_single_beat got=%b exp=0", b_valid); end
    b_rd = 1'b1;
    n = 0;
    while (b_waitReq && n < 20) begin step(); n++; end
    step();
    b_rd = 1'b0;
    n_cmp++; if (b_valid !== 1'b1 || b_dout !== 64'hA5A5_A5A5_A5A5_A5A5) begin n_fail++; $display("FAIL rw_mem_unchanged got=%b/%h exp=1/a5a5a5a5a5a5a5a5", b_valid, b_dout); end
  endtask

  initial begin
    n_cmp = 0; n_fail = 0;
    a_reset = 1'b1; a_rd = 1'b0; a_wr = 1'b0; a_addr = '0; a_len = '0; a_mask = '0; a_din = '0;
    b_reset = 1'b1; b_rd = 1'b0; b_wr = 1'b0; b_addr = '0; b_len = '0; b_mask = '0; b_din = '0;
    @(negedge clk);
    test_reset();
    test_single();
    test_burst_gap();
    test_mask();
    test_wrap();
    test_reset_mid();
    test_busy();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
